// File: rtl/power_seq_if.sv
// Handshake/bus bundle for power_seq.
//   master : the controller/RNG side (drives start, operand, matrix, masks)
//   slave  : the sequencer itself
// Signals:
//   start, n_sq, in_data, B_ext   operation request and operand
//   rnd_req, rnd_valid, r_in      mask request/response from the RNG
//   busy, done, out_data, sq_count status and result
interface power_seq_if #(
    parameter int d      = 2,
    parameter int MAX_SQ = 4,
    parameter int CNT_W  = $clog2(MAX_SQ + 1)
);
    logic                   start;
    logic [CNT_W-1:0]       n_sq;
    logic [(d+1)*8-1:0]     in_data;
    logic [7*8-1:0]         B_ext;
    logic                   rnd_req;
    logic                   rnd_valid;
    logic [d*8-1:0]         r_in;
    logic                   busy;
    logic                   done;
    logic [(d+1)*8-1:0]     out_data;
    logic [CNT_W-1:0]       sq_count;

    modport master (
        output start, n_sq, in_data, B_ext, rnd_valid, r_in,
        input  rnd_req, busy, done, out_data, sq_count
    );

    modport slave (
        input  start, n_sq, in_data, B_ext, rnd_valid, r_in,
        output rnd_req, busy, done, out_data, sq_count
    );
endinterface

// File: rtl/power_seq.sv
// power_seq: iterative sequencer for masked GF(2^8) exponentiation by
// repeated squaring (x -> x^(2^n), n clamped to MAX_SQ).
//
// Data representation: a state is d+1 Boolean shares of 8 bits, share i in
// bits [8i+7:8i]; the plain value is the XOR of all shares. Each squaring
// squares every share (squaring is GF(2)-linear) and refreshes the sharing
// with a fresh d-byte mask from the RNG: share i ^= r_i for i<d and the last
// share absorbs the XOR of all r_i, so the plain value is preserved.
//
// B_ext holds the reduction rows: byte k is x^(8+k) mod P(x), k = 0..6.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (all state and outputs to 0)
//   bus    power_seq_if.slave: start/n_sq/in_data/B_ext in, rnd_req out,
//          rnd_valid/r_in in, busy/done/out_data/sq_count out
module power_seq #(
    parameter int d      = 2,
    parameter int MAX_SQ = 4,
    parameter int CNT_W  = $clog2(MAX_SQ + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    power_seq_if.slave   bus
);
    localparam int ST_W = (d + 1) * 8;
    localparam int R_W  = d * 8;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_DONE = 2'b10;

    logic [1:0]       state;
    logic [ST_W-1:0]  acc;
    logic [CNT_W-1:0] rem;
    logic [CNT_W-1:0] sq_count;
    logic [CNT_W-1:0] n_eff;
    logic             fire;

    // Square one unmasked byte: spread bits to even positions, then fold the
    // high part back with the reduction rows.
    function automatic logic [7:0] gf_sq(input logic [7:0] a, input logic [55:0] b);
        logic [14:0] w;
        logic [7:0]  r;
        w = '0;
        for (int i = 0; i < 8; i++) begin
            w[2*i] = a[i];
        end
        r = w[7:0];
        for (int k = 0; k < 7; k++) begin
            if (w[8+k]) begin
                r = r ^ b[8*k +: 8];
            end
        end
        return r;
    endfunction

    // Masked squaring with remasking by a fresh mask.
    function automatic logic [ST_W-1:0] square(input logic [ST_W-1:0] x,
                                               input logic [R_W-1:0]  r,
                                               input logic [55:0]     b);
        logic [ST_W-1:0] y;
        logic [7:0]      rsum;
        y    = '0;
        rsum = '0;
        for (int i = 0; i < d; i++) begin
            y[8*i +: 8] = gf_sq(x[8*i +: 8], b) ^ r[8*i +: 8];
            rsum        = rsum ^ r[8*i +: 8];
        end
        y[8*d +: 8] = gf_sq(x[8*d +: 8], b) ^ rsum;
        return y;
    endfunction

    always_comb begin
        n_eff = (bus.n_sq > CNT_W'(MAX_SQ)) ? CNT_W'(MAX_SQ) : bus.n_sq;
    end

    // A mask is consumed only while requesting; rnd_valid elsewhere is ignored.
    assign fire = (state == S_RUN) && bus.rnd_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            acc      <= '0;
            rem      <= '0;
            sq_count <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        acc      <= bus.in_data;
                        rem      <= n_eff;
                        sq_count <= '0;
                        state    <= (n_eff == '0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (fire) begin
                        acc      <= square(acc, bus.r_in, bus.B_ext);
                        rem      <= rem - CNT_W'(1);
                        sq_count <= sq_count + CNT_W'(1);
                        if (rem == CNT_W'(1)) begin
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.rnd_req  = (state == S_RUN);
    assign bus.busy     = (state != S_IDLE);
    assign bus.done     = (state == S_DONE);
    assign bus.out_data = acc;
    assign bus.sq_count = sq_count;
endmodule
